period_meter: RTL and testbench

- Measures a slow incoming square wave (`sig_in`) in units of `in_clock` cycles.
- Reports the period and high time of each complete cycle through a valid/ready result port.
- Checks frequency-divided clocks and external slow signals against the fast system clock. It is the measuring end of clock division.
- Contains an input synchronizer, edge detector, measurement FSM, saturating counters, a timeout flag and a one-deep result register with backpressure.

---
 rtl/freq_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 50 +++++
 rtl/period_meter.sv | 153 +++++++++++++++
 tb/tb_period_meter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for slow-signal frequency/period measurement.
// Latency: none (declarations only).
// Backpressure: not applicable.
package freq_pkg;

    // Measurement FSM: IDLE waits for a first rising edge, MEASURE times
    // the span between consecutive rising edges.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

    // Fewer than two flops leaves too little settling time for metastability.
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous slow signal and flags its rising/falling edges.
// Latency: async_in reaches sync_out after SYNC_STAGES clocks; rise/fall are combinational from sync_out.
// Backpressure: none; edges are single-cycle strobes that are never held.
module sync_edge_detect
    import freq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    // A request below the safe minimum is quietly raised to the minimum.
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              s_dly_q;
    logic              s_dly_d;

    assign sync_out = sync_q[STAGES-1];

    // Shift the raw input into the chain and keep a one-cycle-old copy of the output stage.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], async_in};
        s_dly_d = sync_q[STAGES-1];
    end

    // Synchronizer and delay registers; all cleared by reset so a held-high input yields a fresh rise.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

    // Edge strobes compare the synchronized level against its registered copy.
    always_comb begin
        rise = sync_out & ~s_dly_q;
        fall = ~sync_out & s_dly_q;
    end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in in_clock cycles.
// Latency: result valid 1 clock after the second synchronized rise (SYNC_STAGES + 1 after the raw edge).
// Backpressure: one-deep result register; a new result while valid && !ready is dropped and overrun sticks.
module period_meter
    import freq_pkg::*;
#(
    parameter int BITS        = 22,
    parameter int SYNC_STAGES = 2
) (
    input  logic            in_clock,
    input  logic            reset_n,
    input  logic            sig_in,
    input  logic            ready,
    output logic [BITS-1:0] period,
    output logic [BITS-1:0] high_time,
    output logic            valid,
    output logic            overrun,
    output logic            timeout
);

    localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};
    localparam logic [BITS-1:0] CNT_ONE = {{(BITS-1){1'b0}}, 1'b1};

    logic s_sync;
    logic s_rise;
    logic s_fall;

    meas_state_t     state_q,   state_d;
    logic [BITS-1:0] cnt_q,     cnt_d;
    logic [BITS-1:0] hcnt_q,    hcnt_d;
    logic            timeout_q, timeout_d;
    logic            publish;

    logic [BITS-1:0] period_q,  period_d;
    logic [BITS-1:0] high_q,    high_d;
    logic            valid_q,   valid_d;
    logic            overrun_q, overrun_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .in_clock (in_clock),
        .reset_n  (reset_n),
        .async_in (sig_in),
        .sync_out (s_sync),
        .rise     (s_rise),
        .fall     (s_fall)
    );

    // Measurement FSM: counts cycles between rises and high cycles, publishes on rise, times out at all-ones.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        timeout_d = timeout_q;
        publish   = 1'b0;
        case (state_q)
            IDLE: begin
                // Counters stay frozen until a first edge gives a reference point.
                if (s_rise) begin
                    state_d   = MEASURE;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                if (s_rise) begin
                    // The rise cycle itself counts as cycle 1 of the next period.
                    publish   = 1'b1;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    // Period no longer representable: flag it and wait for a fresh pair of rises.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (s_sync) begin
                        hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Result handshake: load when the slot is empty or being drained this cycle, otherwise drop and flag.
    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (publish) begin
            if (!valid_q || ready) begin
                period_d = cnt_q;
                high_d   = hcnt_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Result registers; period/high_time keep their last value after being consumed.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // A level cannot rise and fall in the same cycle; a violation means the edge detector is broken.
    always_ff @(posedge in_clock) begin
        if (reset_n) begin
            assert (!(s_rise && s_fall));
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: a 22-bit instance against a rise-list/handshake model, an 8-bit instance for timeout.
// Latency: model expects publish SYNC_STAGES edges after the sampled raw rise, visible after that edge.
// Backpressure: ready is driven per cycle (held, pulsed, on-publish only, or random).
module tb_period_meter;

    localparam int S = 2;

    logic        in_clock = 1'b0;
    logic        reset_n  = 1'b1;
    logic        sig_in   = 1'b0;
    logic        ready    = 1'b1;
    logic        ready8   = 1'b1;

    logic [21:0] p22, h22;
    logic        v22, o22, t22;
    logic [7:0]  p8, h8;
    logic        v8, o8, t8;

    always #5 in_clock = ~in_clock;

    period_meter #(.BITS(22), .SYNC_STAGES(S)) dut22 (
        .in_clock (in_clock), .reset_n (reset_n), .sig_in (sig_in), .ready (ready),
        .period (p22), .high_time (h22), .valid (v22), .overrun (o22), .timeout (t22)
    );

    period_meter #(.BITS(8), .SYNC_STAGES(S)) dut8 (
        .in_clock (in_clock), .reset_n (reset_n), .sig_in (sig_in), .ready (ready8),
        .period (p8), .high_time (h8), .valid (v8), .overrun (o8), .timeout (t8)
    );

    typedef struct {
        int t;
        int per;
        int hi;
    } pub_t;

    pub_t pq[$];
    int   g;
    bit   prev;
    bit   have_rise;
    int   last_rise;
    int   ones;
    bit   mv, mov;
    int   mp, mh;
    int   vectors;
    int   errors;

    task automatic model_reset();
        pq.delete();
        prev      = 1'b0;
        have_rise = 1'b0;
        last_rise = 0;
        ones      = 0;
        mv        = 1'b0;
        mov       = 1'b0;
        mp        = 0;
        mh        = 0;
    endtask

    // One clock: compare the 22-bit instance to the model, drive x and ready, advance the model by one edge.
    // rmode: 0 ready low, 1 ready high, 2 ready only when a result is published, 3 random.
    task automatic step(input bit x, input int rmode);
        bit rdy;
        bit pub_now;
        @(negedge in_clock);
        vectors++;
        if (v22 !== mv || o22 !== mov || t22 !== 1'b0 || p22 !== mp[21:0] || h22 !== mh[21:0]) begin
            errors++;
            $display("FAIL step22 edge=%0d: got v=%b p=%0d h=%0d ov=%b to=%b, expected v=%b p=%0d h=%0d ov=%b to=0",
                     g - 1, v22, p22, h22, o22, t22, mv, mp, mh, mov);
        end
        sig_in = x;
        if (x && !prev) begin
            if (have_rise) pq.push_back('{g + S, g - last_rise, ones});
            have_rise = 1'b1;
            last_rise = g;
            ones      = 1;
        end else if (x) begin
            ones++;
        end
        prev    = x;
        pub_now = (pq.size() > 0) && (pq[0].t == g);
        case (rmode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = pub_now;
            default: rdy = ($urandom % 2) == 1;
        endcase
        ready = rdy;
        if (pub_now) begin
            if (!mv || rdy) begin
                mp = pq[0].per;
                mh = pq[0].hi;
                mv = 1'b1;
            end else begin
                mov = 1'b1;
            end
            void'(pq.pop_front());
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        g++;
    endtask

    task automatic wave(input int high, input int low, input int periods, input int rmode);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < high; i++) step(1'b1, rmode);
            for (int i = 0; i < low; i++) step(1'b0, rmode);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge arrives.
    task automatic do_reset();
        @(negedge in_clock);
        #2;
        reset_n = 1'b0;
        sig_in  = 1'b0;
        #1;
        vectors++;
        if (v22 !== 1'b0 || o22 !== 1'b0 || t22 !== 1'b0 || p22 !== 22'd0 || h22 !== 22'd0 ||
            v8 !== 1'b0 || o8 !== 1'b0 || t8 !== 1'b0 || p8 !== 8'd0 || h8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: got v=%b p=%0d h=%0d ov=%b to=%b / v8=%b p8=%0d h8=%0d ov8=%b to8=%b, expected all 0",
                     v22, p22, h22, o22, t22, v8, p8, h8, o8, t8);
        end
        repeat (3) @(negedge in_clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1);
    endtask

    task automatic test_basic();
        do_reset();
        wave(4, 6, 6, 1);
    endtask

    task automatic test_backpressure();
        do_reset();
        wave(4, 6, 4, 0);
        step(1'b0, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 0);
        wave(4, 6, 2, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        wave(4, 6, 3, 2);
        wave(5, 7, 3, 2);
        wave(5, 7, 1, 1);
    endtask

    task automatic test_min_period();
        do_reset();
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 1);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            wave($urandom_range(12, 1), $urandom_range(12, 1), 1, 3);
        end
        wave(3, 3, 2, 1);
    endtask

    task automatic test_timeout();
        int g0;
        int g1;
        int edge_n;
        bit exp_to;
        bit exp_v;
        do_reset();
        g0 = g;
        for (int i = 0; i < 305; i++) begin
            step(i < 5, 1);
            edge_n = g - 2;
            exp_to = (edge_n >= g0 + S + 255);
            vectors++;
            if (t8 !== exp_to || v8 !== 1'b0) begin
                errors++;
                $display("FAIL timeout8 edge=%0d: got to=%b v=%b, expected to=%b v=0", edge_n - g0, t8, v8, exp_to);
            end
        end
        g1 = g;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                step(i < 10, 1);
                edge_n = g - 2;
                exp_to = (edge_n < g1 + S);
                exp_v  = (edge_n == g1 + 20 + S) || (edge_n == g1 + 40 + S) || (edge_n == g1 + 60 + S);
                vectors++;
                if (t8 !== exp_to || v8 !== exp_v || (exp_v && (p8 !== 8'd20 || h8 !== 8'd10))) begin
                    errors++;
                    $display("FAIL recover8 edge=%0d: got to=%b v=%b p=%0d h=%0d, expected to=%b v=%b p=20 h=10",
                             edge_n - g1, t8, v8, p8, h8, exp_to, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wave(4, 6, 4, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        do_reset();
        wave(4, 6, 4, 1);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        g       = 0;
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_min_period();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
